gate_bist_seq: RTL and testbench
================================

GATE_BIST_SEQ -- requirements
Module: gate_bist_seq

Interface
REQ-001 SHALL have parameter: SETTLE_CYC, default 2, idle cycles between driving a/b and sampling gate outputs (legal 0..15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request one self-test run.
- a, b  out  1 each  operands driven to the two-input gate block under test.
- and_g, or_g, not_g, nand_g, nor_g, xor_g, xnor_g  in  1 each  gate results returned from the block under test.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  last run had no mismatch.
- err_cnt  out  3  count of failing vectors in last run.
- fail_vec  out  7  sticky per-gate mismatch flags. Bit 0 is and, then or, not, nand, nor, xor; bit 6 is xnor.

Function
REQ-003 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-004 The FSM SHALL transition as follows:
- IDLE to DRIVE when start=1.
- DRIVE to SETTLE, or to CHECK if SETTLE_CYC=0.
- SETTLE to CHECK after SETTLE_CYC cycles.
- CHECK to DONE if idx=3, else to DRIVE with idx+1.
- DONE to IDLE.
REQ-005 On leaving IDLE, SHALL clear idx, err_cnt, fail_vec and pass in the same edge.
REQ-006 SHALL apply vectors in order idx=0,1,2,3 with a=idx[1], b=idx[0], registered, updated on entry to DRIVE.
REQ-007 a and b SHALL hold their values through SETTLE and CHECK.
REQ-008 In CHECK, SHALL compute expected values from registered a/b: and, or, not(a), nand, nor, xor, xnor.
REQ-009 In CHECK, SHALL OR each per-gate mismatch into fail_vec.
REQ-010 In CHECK, SHALL increment err_cnt by exactly 1 if any bit mismatches; max value is 4, with no wrap.
REQ-011 done SHALL be high only in DONE, for exactly one cycle.
REQ-012 pass SHALL be set in DONE to (fail_vec==0) and held until the next start is accepted.
REQ-013 err_cnt and fail_vec SHALL hold until the next start is accepted.
REQ-014 busy SHALL be 1 in DRIVE, SETTLE, CHECK and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored outside IDLE; a start held high SHALL begin a new run from IDLE after DONE.
REQ-016 Latency SHALL be: with start sampled at edge 0, done is high in the cycle after edge 4*(SETTLE_CYC+2)+1. For SETTLE_CYC=2 this is edge 17.
REQ-017 Gate inputs SHALL be sampled only in CHECK; values in other states have no effect.

Reset
REQ-018 On rst_n low, SHALL immediately and asynchronously force IDLE and idx=0.
REQ-019 On rst_n low, SHALL force a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-020 Reset mid-run SHALL abandon the run with no done pulse; the first start after release SHALL run all vectors from idx=0.

Configuration
REQ-021 With GATE_BIST_STOP_ON_FAIL_EN defined, CHECK with any mismatch SHALL go directly to DONE, abandoning the remaining vectors.
REQ-022 Without GATE_BIST_STOP_ON_FAIL_EN, all four vectors SHALL always run and err_cnt can reach 4.

Verification
REQ-023 Fault-free gate block, SETTLE_CYC=2, 1-cycle start -> a/b run 00,01,10,11; done at edge 17; pass=1; err_cnt=0; fail_vec=7'b0000000.
REQ-024 xor_g stuck at 0, no macro -> err_cnt=2 (vectors 01, 10); fail_vec=7'b0100000; pass=0; done at edge 17.
REQ-025 Same fault, GATE_BIST_STOP_ON_FAIL_EN defined -> done at edge 9 after vector 01; err_cnt=1; fail_vec=7'b0100000; pass=0.
REQ-026 not_g stuck at 1 -> fails vectors 10 and 11; err_cnt=2; fail_vec=7'b0000100.
REQ-027 rst_n pulsed low during SETTLE of vector 10 -> a=b=0 and busy=0 immediately; no done pulse; next start gives a full clean run with pass=1.
REQ-028 SETTLE_CYC=0 with start held high for 20 cycles -> first done at edge 9; second run begins from IDLE; start never restarts a run mid-flight.

Source files
------------

// File: rtl/gate_bist_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate_bist_seq
// Description : Built-in self-test sequencer for a block of seven 2-input
//               logic gates (and, or, not(a), nand, nor, xor, xnor).
//               It walks a/b through 00,01,10,11. After each vector it waits
//               SETTLE_CYC idle cycles, then compares the returned gate
//               results against expected values. It reports a sticky
//               per-gate fail mask, a failing-vector count and a pass flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYC   idle cycles between driving a/b and sampling (0..15)
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request one self-test run (acted on only in IDLE)
//   a, b         operands to the gate block under test (registered)
//   and_g..xnor_g gate results returned from the block under test
//   busy         run in progress
//   done         one-cycle pulse at the end of a run
//   pass         last run had no mismatch
//   err_cnt      number of failing vectors in the last run (0..4)
//   fail_vec     sticky per-gate mismatch flags
//                [0]=and [1]=or [2]=not [3]=nand [4]=nor [5]=xor [6]=xnor
// Build option
//   GATE_BIST_STOP_ON_FAIL_EN  when defined, the first failing vector
//                              ends the run immediately
// ============================================================================
module gate_bist_seq #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       and_g,
    input  logic       or_g,
    input  logic       not_g,
    input  logic       nand_g,
    input  logic       nor_g,
    input  logic       xor_g,
    input  logic       xnor_g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [6:0] fail_vec
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Last value of the settle counter before moving to CHECK. When
    // SETTLE_CYC is 0 the SETTLE state is never entered, so the wrapped
    // value is never used.
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYC - 1);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit c_stop_on_fail = 1'b1;
`else
    localparam bit c_stop_on_fail = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [2:0] err_q, err_d;
    logic [6:0] fv_q, fv_d;
    logic       pass_q, pass_d;
    logic       start_q;

    logic [6:0] w_exp;
    logic [6:0] w_got;
    logic [6:0] w_mis;
    logic       w_any;

    // Expected gate results come from the registered operands, so they are
    // stable for the whole DRIVE/SETTLE/CHECK window of a vector.
    assign w_exp = {~(a_q ^ b_q), (a_q ^ b_q), ~(a_q | b_q), ~(a_q & b_q),
                    ~a_q, (a_q | b_q), (a_q & b_q)};
    assign w_got = {xnor_g, xor_g, nor_g, nand_g, not_g, or_g, and_g};
    assign w_mis = w_exp ^ w_got;
    assign w_any = |w_mis;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
            fv_q    <= 7'd0;
            pass_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
            start_q <= start;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        fv_d    = fv_q;
        pass_d  = pass_q;

        unique case (state_q)
            ST_IDLE: begin
                // start is taken through one register stage, so a request
                // sampled at edge N leaves IDLE at edge N+1.
                if (start_q) begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    err_d   = 3'd0;
                    fv_d    = 7'd0;
                    pass_d  = 1'b0;
                end
            end

            ST_DRIVE: begin
                cnt_d = 4'd0;
                if (SETTLE_CYC == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == c_settle_last) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_CHECK: begin
                fv_d = fv_q | w_mis;
                // At most four vectors can fail; the guard keeps the count
                // from ever wrapping.
                if (w_any && (err_q != 3'd4)) begin
                    err_d = err_q + 3'd1;
                end
                if ((idx_q == 2'd3) || (c_stop_on_fail && w_any)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                end
            end

            ST_DONE: begin
                pass_d  = (fv_q == 7'd0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a        = a_q;
    assign b        = b_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fv_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_bist_seq
// Description : Self-checking bench for gate_bist_seq. Instance u_dut0 uses
//               SETTLE_CYC=2 with an injectable-fault gate block. Instance
//               u_dut1 uses SETTLE_CYC=0 with a fault-free gate block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_bist_seq;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // ---------------- instance 0 : SETTLE_CYC = 2 ----------------
    logic       start0, a0, b0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [6:0] fv0;
    logic [6:0] s0_mask, s1_mask;
    logic [6:0] ideal0, g0;

    assign ideal0 = {~(a0 ^ b0), a0 ^ b0, ~(a0 | b0), ~(a0 & b0), ~a0, a0 | b0, a0 & b0};
    assign g0     = (ideal0 & ~s0_mask) | s1_mask;

    gate_bist_seq #(.SETTLE_CYC(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
        .and_g(g0[0]), .or_g(g0[1]), .not_g(g0[2]), .nand_g(g0[3]),
        .nor_g(g0[4]), .xor_g(g0[5]), .xnor_g(g0[6]),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );

    // ---------------- instance 1 : SETTLE_CYC = 0 ----------------
    logic       start1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [6:0] fv1;

    gate_bist_seq #(.SETTLE_CYC(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .and_g(a1 & b1), .or_g(a1 | b1), .not_g(~a1), .nand_g(~(a1 & b1)),
        .nor_g(~(a1 | b1)), .xor_g(a1 ^ b1), .xnor_g(~(a1 ^ b1)),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        logic [6:0] s0;
        logic [6:0] s1;
        int         err;
        int         fv;
        int         pass;
        int         err_s;
        int         fv_s;
        int         done_s;
    } vec_t;

    typedef struct {
        int err;
        int fv;
        int pass;
        int done_e;
    } exp_t;

    vec_t tbl[8];
    exp_t sb_q[$];

    // One run on u_dut0: edge 0 is the edge that samples start. Outputs are
    // sampled 1 ns after every later rising edge k.
    task automatic run0(input exp_t e);
        int   done_at;
        int   n_done;
        exp_t got;
        done_at = -1;
        n_done  = 0;
        sb_q.push_back(e);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            // CHECK cycle of vector v: DRIVE at edge 1+4v, CHECK at 4v+4
            for (int v = 0; v < 4; v++) begin
                if (k == 4 * v + 4 && done_at < 0) begin
                    chk("ab_vec", int'({a0, b0}), v);
                end
            end
            if (done_at > 0 && k == done_at + 1) begin
                got = sb_q.pop_front();
                chk("done_edge", done_at, got.done_e);
                chk("err_cnt", int'(err0), got.err);
                chk("fail_vec", int'(fv0), got.fv);
                chk("pass", int'(pass0), got.pass);
            end
        end
        if (done_at < 0) begin
            $display("FAIL done_timeout actual=none required=%0d", e.done_e);
            n_chk++;
            void'(sb_q.pop_front());
        end
        chk("done_width", n_done, 1);
        chk("idle_after", int'(busy0), 0);
        chk("err_held", int'(err0), e.err);
        chk("pass_held", int'(pass0), e.pass);
    endtask

    initial begin
        exp_t e;
        int   n_done;
        int   d_edge[$];

        //            s0     s1    err  fv     pass err_s fv_s   done_s
        tbl[0] = '{7'h00, 7'h00, 0, 7'h00, 1, 0, 7'h00, 17};
        tbl[1] = '{7'h20, 7'h00, 2, 7'h20, 0, 1, 7'h20, 9};
        tbl[2] = '{7'h00, 7'h04, 2, 7'h04, 0, 1, 7'h04, 13};
        tbl[3] = '{7'h00, 7'h01, 3, 7'h01, 0, 1, 7'h01, 5};
        tbl[4] = '{7'h7F, 7'h00, 4, 7'h7F, 0, 1, 7'h5C, 5};
        tbl[5] = '{7'h00, 7'h10, 3, 7'h10, 0, 1, 7'h10, 9};
        tbl[6] = '{7'h0A, 7'h00, 4, 7'h0A, 0, 1, 7'h08, 5};
        tbl[7] = '{7'h00, 7'h00, 0, 7'h00, 1, 0, 7'h00, 17};

        rst_n   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        s0_mask = 7'h00;
        s1_mask = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", int'(a0), 0);
        chk("rst_b", int'(b0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_fv", int'(fv0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table-driven runs ----
        for (int i = 0; i < 8; i++) begin
            s0_mask  = tbl[i].s0;
            s1_mask  = tbl[i].s1;
            e.err    = STOP ? tbl[i].err_s : tbl[i].err;
            e.fv     = STOP ? tbl[i].fv_s : tbl[i].fv;
            e.pass   = tbl[i].pass;
            e.done_e = STOP ? tbl[i].done_s : 17;
            run0(e);
        end

        // ---- reset during SETTLE of vector 10 ----
        s0_mask = 7'h00;
        s1_mask = 7'h00;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        // vector 10 is driven at edge 9 and settles from edge 10
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_ab", int'({a0, b0}), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", int'(a0), 0);
        chk("async_rst_b", int'(b0), 0);
        chk("async_rst_busy", int'(busy0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done0) n_done++;
        end
        chk("no_done_after_rst", n_done, 0);
        e.err = 0; e.fv = 0; e.pass = 1; e.done_e = 17;
        run0(e);

        // ---- SETTLE_CYC = 0, start held for 20 sampled edges ----
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done1) d_edge.push_back(k);
            // first run DRIVE at 1+2v; second run DRIVE at 11+2v
            for (int v = 0; v < 4; v++) begin
                if (k == 2 * v + 2) chk("s0_run1_ab", int'({a1, b1}), v);
                if (k == 2 * v + 12) chk("s0_run2_ab", int'({a1, b1}), v);
            end
            if (k == 10) begin
                chk("s0_idle_gap", int'(busy1), 0);
                chk("s0_pass", int'(pass1), 1);
            end
            if (k == 11) chk("s0_restart", int'(busy1), 1);
            if (k == 19) start1 = 1'b0;
        end
        if (d_edge.size() >= 2) begin
            chk("s0_done1", d_edge[0], 9);
            chk("s0_done2", d_edge[1], 19);
        end else begin
            $display("FAIL s0_done_count actual=%0d required=2", d_edge.size());
            n_chk++;
        end
        chk("s0_final_idle", int'(busy1), 0);
        chk("s0_final_err", int'(err1), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
